// File: rtl/sram_cycle_ctrl_if.sv
// Requester-side handshake of the SRAM cycle controller: single-cycle
// write/read strobes in, read data / status back out.
interface sram_cycle_ctrl_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic                  iWrite;
  logic                  iRead;
  logic [ADDR_W-1:0]     iAddress;
  logic [DATA_W-1:0]     iWritedata;
  logic [DATA_W/8-1:0]   iByteEn;
  logic [DATA_W-1:0]     oReaddata;
  logic                  oReaddatavalid;
  logic                  oBusy;
  logic                  oOverrun;

  // Pattern generator side
  modport master (
    output iWrite, iRead, iAddress, iWritedata, iByteEn,
    input  oReaddata, oReaddatavalid, oBusy, oOverrun
  );

  // Controller side
  modport slave (
    input  iWrite, iRead, iAddress, iWritedata, iByteEn,
    output oReaddata, oReaddatavalid, oBusy, oOverrun
  );
endinterface

// File: rtl/sram_cycle_ctrl.sv
// Asynchronous SRAM cycle controller. Turns one-cycle write/read strobes
// into timed CE_n/OE_n/WE_n/BE_n bus cycles with a split data bus. Every
// output is a flop; the whole controller is one registered FSM.
module sram_cycle_ctrl #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int WR_WAIT = 2,
  parameter int RD_WAIT = 2,
  parameter int TURN    = 1
) (
  input  logic                  iCLK,
  input  logic                  iRST_n,
  sram_cycle_ctrl_if.slave      bus,
  output logic [ADDR_W-1:0]     oSRAM_ADDR,
  output logic [DATA_W-1:0]     oSRAM_DQ,
  output logic                  oSRAM_DQ_OE,
  input  logic [DATA_W-1:0]     iSRAM_DQ,
  output logic                  oSRAM_CE_n,
  output logic                  oSRAM_OE_n,
  output logic                  oSRAM_WE_n,
  output logic [DATA_W/8-1:0]   oSRAM_BE_n
);

  localparam int BE_W     = DATA_W / 8;
  localparam int MAX_WAIT = (WR_WAIT > RD_WAIT) ?
                            ((WR_WAIT > TURN) ? WR_WAIT : TURN) :
                            ((RD_WAIT > TURN) ? RD_WAIT : TURN);
  localparam int CNT_W    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  // Wait counter load values; the counter runs down and parks at zero.
  localparam logic [CNT_W-1:0] WR_CNT   = CNT_W'(WR_WAIT);
  localparam logic [CNT_W-1:0] RD_CNT   = CNT_W'(RD_WAIT);
  localparam logic [CNT_W-1:0] TURN_CNT = CNT_W'((TURN > 0) ? TURN - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RD_ACCESS,
    TURNAROUND
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             req;
  logic             cnt_zero;

  assign req      = bus.iWrite | bus.iRead;
  assign cnt_zero = (cnt == '0);

  // Controller FSM with all bus and status outputs registered alongside it.
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state              <= IDLE;
      cnt                <= '0;
      oSRAM_CE_n         <= 1'b1;
      oSRAM_OE_n         <= 1'b1;
      oSRAM_WE_n         <= 1'b1;
      oSRAM_BE_n         <= '1;
      oSRAM_DQ_OE        <= 1'b0;
      oSRAM_ADDR         <= '0;
      oSRAM_DQ           <= '0;
      bus.oReaddata      <= '0;
      bus.oReaddatavalid <= 1'b0;
      bus.oBusy          <= 1'b0;
      bus.oOverrun       <= 1'b0;
    end else begin
      bus.oReaddatavalid <= 1'b0;
      // Any strobe seen while busy is dropped; remember that it happened.
      if (req && bus.oBusy)
        bus.oOverrun <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.iWrite) begin
            // Write wins over a simultaneous read; the read is simply lost.
            oSRAM_ADDR  <= bus.iAddress;
            oSRAM_DQ    <= bus.iWritedata;
            oSRAM_BE_n  <= ~bus.iByteEn;
            oSRAM_CE_n  <= 1'b0;
            oSRAM_OE_n  <= 1'b1;
            oSRAM_WE_n  <= 1'b1;
            oSRAM_DQ_OE <= 1'b1;
            bus.oBusy   <= 1'b1;
            state       <= WR_SETUP;
          end else if (bus.iRead) begin
            oSRAM_ADDR  <= bus.iAddress;
            oSRAM_BE_n  <= '0;
            oSRAM_CE_n  <= 1'b0;
            oSRAM_OE_n  <= 1'b0;
            oSRAM_WE_n  <= 1'b1;
            oSRAM_DQ_OE <= 1'b0;
            cnt         <= RD_CNT;
            bus.oBusy   <= 1'b1;
            state       <= RD_ACCESS;
          end
        end

        WR_SETUP: begin
          // Address/data/CE have had one cycle to settle before WE falls.
          oSRAM_WE_n <= 1'b0;
          cnt        <= WR_CNT;
          state      <= WR_PULSE;
        end

        WR_PULSE: begin
          if (cnt_zero) begin
            oSRAM_WE_n <= 1'b1;
            state      <= WR_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        WR_HOLD: begin
          // Data and CE held one cycle past WE rising, then release the bus.
          oSRAM_CE_n  <= 1'b1;
          oSRAM_OE_n  <= 1'b1;
          oSRAM_WE_n  <= 1'b1;
          oSRAM_BE_n  <= '1;
          oSRAM_DQ_OE <= 1'b0;
          cnt         <= TURN_CNT;
          bus.oBusy   <= (TURN != 0);
          state       <= (TURN != 0) ? TURNAROUND : IDLE;
        end

        RD_ACCESS: begin
          if (cnt_zero) begin
            bus.oReaddata      <= iSRAM_DQ;
            bus.oReaddatavalid <= 1'b1;
            oSRAM_CE_n         <= 1'b1;
            oSRAM_OE_n         <= 1'b1;
            oSRAM_WE_n         <= 1'b1;
            oSRAM_BE_n         <= '1;
            oSRAM_DQ_OE        <= 1'b0;
            cnt                <= TURN_CNT;
            bus.oBusy          <= (TURN != 0);
            state              <= (TURN != 0) ? TURNAROUND : IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        TURNAROUND: begin
          // Bus idle gap so the SRAM's output driver is off before reuse.
          if (cnt_zero) begin
            bus.oBusy <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          oSRAM_CE_n  <= 1'b1;
          oSRAM_OE_n  <= 1'b1;
          oSRAM_WE_n  <= 1'b1;
          oSRAM_BE_n  <= '1;
          oSRAM_DQ_OE <= 1'b0;
          bus.oBusy   <= 1'b0;
          cnt         <= '0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // BE_W documents the byte-lane count tied to DATA_W.
  logic [BE_W-1:0] unused_be_w;
  assign unused_be_w = '0;

endmodule

// File: tb/tb_sram_cycle_ctrl.sv
// Bench for sram_cycle_ctrl: two instances (default timing and all-zero
// timing), each hooked to a behavioural async SRAM, checked every cycle
// against a window-based reference of when each strobe must be active.
module tb_sram_cycle_ctrl;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int BW = DW / 8;
  localparam int WW [2] = '{2, 0};
  localparam int RW [2] = '{2, 0};
  localparam int TN [2] = '{1, 0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_cycle_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
  sram_cycle_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();

  logic [1:0][AW-1:0] s_addr;
  logic [1:0][DW-1:0] s_dq;
  logic [1:0][DW-1:0] s_q;
  logic [1:0][BW-1:0] s_be_n;
  logic [1:0]         s_dqoe, s_ce_n, s_oe_n, s_we_n;
  logic [1:0]         busy, vld, ovr;
  logic [1:0][DW-1:0] rdata;

  sram_cycle_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WR_WAIT(2), .RD_WAIT(2), .TURN(1)) u_dut (
    .iCLK(clk), .iRST_n(rst_n), .bus(ifa),
    .oSRAM_ADDR(s_addr[0]), .oSRAM_DQ(s_dq[0]), .oSRAM_DQ_OE(s_dqoe[0]),
    .iSRAM_DQ(s_q[0]), .oSRAM_CE_n(s_ce_n[0]), .oSRAM_OE_n(s_oe_n[0]),
    .oSRAM_WE_n(s_we_n[0]), .oSRAM_BE_n(s_be_n[0])
  );

  sram_cycle_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WR_WAIT(0), .RD_WAIT(0), .TURN(0)) u_dut0 (
    .iCLK(clk), .iRST_n(rst_n), .bus(ifb),
    .oSRAM_ADDR(s_addr[1]), .oSRAM_DQ(s_dq[1]), .oSRAM_DQ_OE(s_dqoe[1]),
    .iSRAM_DQ(s_q[1]), .oSRAM_CE_n(s_ce_n[1]), .oSRAM_OE_n(s_oe_n[1]),
    .oSRAM_WE_n(s_we_n[1]), .oSRAM_BE_n(s_be_n[1])
  );

  assign busy[0] = ifa.oBusy;  assign busy[1] = ifb.oBusy;
  assign vld[0]  = ifa.oReaddatavalid; assign vld[1] = ifb.oReaddatavalid;
  assign ovr[0]  = ifa.oOverrun; assign ovr[1] = ifb.oOverrun;
  assign rdata[0] = ifa.oReaddata; assign rdata[1] = ifb.oReaddata;

  function automatic longint mkey(int d, logic [AW-1:0] a);
    return (longint'(d) << 32) | longint'(a);
  endfunction

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] nw, logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++)
      if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // ---------------- async SRAM pin model ----------------
  // A write is committed when WE_n rises while CE_n is still low; a cycle
  // cut short by CE_n rising with WE_n (reset) writes nothing.
  logic [DW-1:0] mem [longint];
  bit            armed [2];
  longint        wkey [2];
  logic [DW-1:0] wdat [2];
  logic [BW-1:0] wbe [2];

  function automatic logic [DW-1:0] memget(longint k);
    return mem.exists(k) ? mem[k] : '0;
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!s_ce_n[d] && !s_we_n[d]) begin
        armed[d] = 1'b1;
        wkey[d]  = mkey(d, s_addr[d]);
        wdat[d]  = s_dqoe[d] ? s_dq[d] : '0;
        wbe[d]   = ~s_be_n[d];
      end else if (armed[d] && !s_ce_n[d]) begin
        mem[wkey[d]] = merge(memget(wkey[d]), wdat[d], wbe[d]);
        armed[d] = 1'b0;
      end else if (s_ce_n[d]) begin
        armed[d] = 1'b0;
      end
      s_q[d] = (!s_ce_n[d] && !s_oe_n[d]) ? memget(mkey(d, s_addr[d])) : '0;
    end
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [longint];
  int            busy_last [2], vld_c [2], pw_c [2];
  int            ce_s [2], ce_e [2], we_s [2], we_e [2], oe_s [2], oe_e [2];
  bit            acc_wr [2], exp_ovr [2];
  logic [AW-1:0] exp_addr [2];
  logic [DW-1:0] exp_dq [2], exp_rd [2], pend_rd [2], pw_dat [2];
  logic [BW-1:0] exp_be_n [2], pw_be [2];
  longint        pw_key [2];

  function automatic logic [DW-1:0] refget(longint k);
    return ref_mem.exists(k) ? ref_mem[k] : '0;
  endfunction

  int n_chk = 0;
  int n_err = 0;
  int cur_d = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cyc %0d got %h exp %h", tag, cur_d, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      busy_last[d] = -1; vld_c[d] = -1; pw_c[d] = -1;
      ce_s[d] = 1; ce_e[d] = 0; we_s[d] = 1; we_e[d] = 0; oe_s[d] = 1; oe_e[d] = 0;
      acc_wr[d] = 1'b0; exp_ovr[d] = 1'b0;
      exp_addr[d] = '0; exp_dq[d] = '0; exp_rd[d] = '0; pend_rd[d] = '0;
      exp_be_n[d] = '1;
    end
  endtask

  // Request in cycle m: accepted only if the previous access's busy span
  // has ended; otherwise it only raises the overrun flag.
  task automatic model_req(int d, bit w, bit r, logic [AW-1:0] a, logic [DW-1:0] wd, logic [BW-1:0] be);
    int m;
    m = cyc;
    if (!(w || r)) return;
    if (m <= busy_last[d]) begin
      exp_ovr[d] = 1'b1;
      return;
    end
    exp_addr[d] = a;
    ce_s[d] = m + 1;
    if (w) begin
      acc_wr[d] = 1'b1;
      exp_dq[d] = wd; exp_be_n[d] = ~be;
      ce_e[d] = m + 3 + WW[d];
      we_s[d] = m + 2; we_e[d] = m + 2 + WW[d];
      oe_s[d] = 1; oe_e[d] = 0;
      busy_last[d] = m + 3 + WW[d] + TN[d];
      pw_c[d] = m + 3 + WW[d];
      pw_key[d] = mkey(d, a); pw_dat[d] = wd; pw_be[d] = be;
    end else begin
      acc_wr[d] = 1'b0;
      ce_e[d] = m + 1 + RW[d];
      oe_s[d] = m + 1; oe_e[d] = m + 1 + RW[d];
      we_s[d] = 1; we_e[d] = 0;
      busy_last[d] = m + 1 + RW[d] + TN[d];
      vld_c[d] = m + 2 + RW[d];
      pend_rd[d] = refget(mkey(d, a));
    end
  endtask

  task automatic check_cycle(int d);
    int m;
    bit in_ce, in_we, in_oe;
    logic [BW-1:0] be_exp;
    m = cyc;
    if (m == vld_c[d]) exp_rd[d] = pend_rd[d];
    in_ce = (m >= ce_s[d]) && (m <= ce_e[d]);
    in_we = (m >= we_s[d]) && (m <= we_e[d]);
    in_oe = (m >= oe_s[d]) && (m <= oe_e[d]);
    be_exp = in_ce ? (acc_wr[d] ? exp_be_n[d] : '0) : '1;
    chk("busy",    busy[d],   m <= busy_last[d]);
    chk("we_n",    s_we_n[d], !in_we);
    chk("oe_n",    s_oe_n[d], !in_oe);
    chk("ce_n",    s_ce_n[d], !in_ce);
    chk("dq_oe",   s_dqoe[d], in_ce && acc_wr[d]);
    chk("be_n",    s_be_n[d], be_exp);
    chk("addr",    s_addr[d], exp_addr[d]);
    chk("dq",      s_dq[d],   exp_dq[d]);
    chk("rvalid",  vld[d],    m == vld_c[d]);
    chk("rdata",   rdata[d],  exp_rd[d]);
    chk("overrun", ovr[d],    exp_ovr[d]);
    chk("we_oe_excl",   !s_we_n[d] && !s_oe_n[d], 0);
    chk("oe_dqoe_excl", s_dqoe[d] && !s_oe_n[d], 0);
    if (m == pw_c[d])
      ref_mem[pw_key[d]] = merge(refget(pw_key[d]), pw_dat[d], pw_be[d]);
  endtask

  task automatic drive(int d, bit w, bit r, logic [AW-1:0] a, logic [DW-1:0] wd, logic [BW-1:0] be);
    ifa.iWrite = (d == 0) && w; ifa.iRead = (d == 0) && r;
    ifa.iAddress = a; ifa.iWritedata = wd; ifa.iByteEn = be;
    ifb.iWrite = (d == 1) && w; ifb.iRead = (d == 1) && r;
    ifb.iAddress = a; ifb.iWritedata = wd; ifb.iByteEn = be;
  endtask

  task automatic cyc_req(int d, bit w, bit r, logic [AW-1:0] a, logic [DW-1:0] wd, logic [BW-1:0] be);
    @(negedge clk);
    cur_d = d;
    check_cycle(d);
    drive(d, w, r, a, wd, be);
    model_req(d, w, r, a, wd, be);
  endtask

  task automatic idle(int d, int n);
    repeat (n) cyc_req(d, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // One reset cycle; both instances must show their reset values.
  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      cur_d = d;
      chk("rst_we_n",  s_we_n[d], 1);
      chk("rst_oe_n",  s_oe_n[d], 1);
      chk("rst_ce_n",  s_ce_n[d], 1);
      chk("rst_be_n",  s_be_n[d], {BW{1'b1}});
      chk("rst_dq_oe", s_dqoe[d], 0);
      chk("rst_addr",  s_addr[d], 0);
      chk("rst_dq",    s_dq[d],   0);
      chk("rst_rdata", rdata[d],  0);
      chk("rst_valid", vld[d],    0);
      chk("rst_busy",  busy[d],   0);
      chk("rst_ovr",   ovr[d],    0);
    end
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic preload(int d, logic [AW-1:0] a, logic [DW-1:0] v);
    mem[mkey(d, a)] = v;
    ref_mem[mkey(d, a)] = v;
  endtask

  task automatic rand_run(int d, int n);
    int sel;
    bit w, r;
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      w = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 2) == 0);
      sel = $urandom_range(0, 7);
      a = (sel == 7) ? {AW{1'b1}} : AW'(sel);
      cyc_req(d, w, r, a, DW'($urandom), BW'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    model_reset();
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    repeat (2) @(negedge clk);
    do_reset();

    // Plain write, then preloaded all-ones address read.
    cyc_req(0, 1, 0, 24'h000003, 16'h5555, 2'b11);
    idle(0, 8);
    preload(0, 24'hFFFFFF, 16'hA5C3);
    cyc_req(0, 0, 1, 24'hFFFFFF, '0, '0);
    idle(0, 6);

    // Strobes held every cycle through a write: overrun, then no-bubble accept.
    cyc_req(0, 1, 0, 24'h000010, 16'h1111, 2'b01);
    for (int i = 0; i < 8; i++)
      cyc_req(0, i[0], !i[0], AW'(24'h11 + i), DW'(16'h2222 + i), 2'b11);
    idle(0, 10);
    cyc_req(0, 0, 1, 24'h000010, '0, '0);
    idle(0, 5);
    cyc_req(0, 0, 1, 24'h000012, '0, '0);
    idle(0, 5);

    // Simultaneous write and read in idle: write only, no overrun.
    do_reset();
    cyc_req(0, 1, 1, 24'h000020, 16'h1234, 2'b11);
    idle(0, 8);
    cyc_req(0, 0, 1, 24'h000020, '0, '0);
    idle(0, 6);

    // Reset in the middle of the write pulse; old data must survive.
    cyc_req(0, 1, 0, 24'h000003, 16'hBEEF, 2'b11);
    idle(0, 3);
    do_reset();
    cyc_req(0, 0, 1, 24'h000003, '0, '0);
    idle(0, 6);

    rand_run(0, 3000);
    idle(0, 10);

    // Zero-wait instance.
    do_reset();
    cyc_req(1, 1, 0, 24'hFFFFFF, 16'h0F0F, 2'b10);
    idle(1, 4);
    cyc_req(1, 0, 1, 24'hFFFFFF, '0, '0);
    idle(1, 3);
    for (int i = 0; i < 10; i++)
      cyc_req(1, 0, 1, AW'(i % 3), '0, '0);
    idle(1, 3);
    rand_run(1, 10000);
    idle(1, 6);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
